imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Synthesizable writer side of the CPU instruction memory. It receives a program as a byte stream, packs little-endian 32-bit words and writes them into instruction memory.
- Holds the pipelined CPU in reset until the whole image is written.
- Publishes the last valid instruction byte address, which replaces the CPU's constant max-instruction-address parameter.
- Sits between a byte source (UART receiver or debug port) and the CPU's instruction memory write port.

Parameters:
- ADDR_WIDTH, 10, word-address width of instruction memory (depth 2**ADDR_WIDTH = 1024 words)
- DATA_WIDTH, 32, instruction word width; fixed at 4 bytes, other values unsupported

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  single-cycle pulse; re-arms the loader from DONE or ERR
- in_valid  in  1  byte source has a byte
- in_data  in  8  byte value
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  word to write
- cpu_hold  out  1  high = keep CPU in reset
- done  out  1  image loaded
- error  out  1  load failed
- last_pc  out  32  byte address of last loaded instruction

Behaviour:
- Handshake: a byte transfers when in_valid && in_ready on a rising edge. in_data is sampled only then.
- Stream format:
  - Header: word count N, 16-bit, low byte first.
  - Body: N words, each 4 bytes, least-significant byte first.
- States: HDR_LO, HDR_HI, BYTE, WRITE, DONE, ERR.
- Reset (rst==0 at a clock edge):
  - State goes to HDR_LO.
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, last_pc=0, cpu_hold=1.
  - Byte counter = 0, word counter = 0.
  - in_ready is 0 during reset; it is 1 in the first cycle after rst goes high.
- in_ready = 1 in HDR_LO, HDR_HI and BYTE; 0 in WRITE, DONE and ERR.
- State transitions:
  - HDR_LO: accept a byte into N[7:0], go to HDR_HI.
  - HDR_HI: accept a byte into N[15:8]. If N==0 or N > 2**ADDR_WIDTH, go to ERR; else go to BYTE.
  - BYTE: accept the byte into lane byte_cnt of the assembly register. When byte_cnt==3 on accept, go to WRITE.
  - WRITE (exactly one cycle): mem_we=1, mem_addr=word_cnt, mem_wdata=assembled word. If word_cnt==N-1, go to DONE; else word_cnt+1 and go to BYTE.
  - DONE: done=1, cpu_hold=0, last_pc=(N-1)*4, zero-extended to 32 bits.
  - ERR: error=1, cpu_hold=1, last_pc=0.
- Timing:
  - mem_we rises the cycle after the 4th byte of a word is accepted.
  - Minimum 5 cycles per word; the last word's write is followed by done in the next cycle.
  - mem_we is never high outside WRITE.
- start handling:
  - Honoured only in DONE or ERR. Next state is HDR_LO; done, error and last_pc clear; cpu_hold=1; counters clear.
  - Ignored in all loading states.
- Stream stalls: in_valid low for any number of cycles simply stalls; there is no timeout.
- Reset mid-load: returns to the reset state. Words already written stay in memory and are not cleared.
- rst low and start high in the same cycle: reset wins.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, state CHK (in_ready=1) accepts one trailing byte.
  - The expected value is the XOR of all 4N body bytes; header bytes are excluded.
  - Match goes to DONE; mismatch goes to ERR.
- Undefined:
  - No CHK state, no trailing byte.
  - The last WRITE goes directly to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - state encoding localparams
  - HDR_BYTES=2, BYTES_PER_WORD=4
  - the checksum width constant
- One sub-module, imem_word_pack:
  - 2-bit byte counter plus 32-bit little-endian assembly register
  - outputs word and word_full
  - cleared by the parent on reset or start

Test Plan:
- Load N=3, words 0x00000013, 0x00100093, 0xFFF00113, streamed back-to-back -> three mem_we pulses at addresses 0,1,2 with those data; done=1, last_pc=0x8, cpu_hold falls together with done.
- Same image with in_valid toggling every other cycle -> identical writes and final state; mem_we never high while in_ready=1.
- Header N=0, then N=1025 with ADDR_WIDTH=10 -> ERR, error=1, cpu_hold=1, no mem_we; subsequent bytes are not accepted.
- Reset asserted after 2 of 4 bytes of word 1 -> all outputs at reset values next cycle; a fresh N=18 load gives last_pc=0x44 and 18 writes.
- start in DONE, then reload N=1, word 0xDEADBEEF -> cpu_hold=1 during the load, write to address 0, last_pc=0x0, done=1.
- With IMEM_LOADER_CHECKSUM_EN, N=1, bytes EF BE AD DE -> checksum 0x22 gives done; 0x23 gives error=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Macro IMEM_LOADER_CHECKSUM_EN adds the trailing XOR checksum byte.
package imem_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;
  // the checksum is one stream byte, so it sets the byte width
  localparam int BYTE_W         = CSUM_W;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int HDR_W          = HDR_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    S_HDR_LO = 3'd0,
    S_HDR_HI = 3'd1,
    S_BYTE   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    S_CHK    = 3'd6
`endif
  } state_e;

endpackage

// File: rtl/imem_word_pack.sv
// Packs four stream bytes into one little-endian 32-bit word.
// Ports: clk, rst (sync, active-low), clr, push, byte_in -> word, word_full.
module imem_word_pack
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (push) begin
      cnt_d = cnt_q + 2'd1;
      word_d[{cnt_q, 3'b000} +: BYTE_W] = byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;
  // this push lands in the top lane and completes the word
  assign word_full = push && !clr &&
    (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader; holds the CPU until loaded.
// Ports: clk, rst, start, in_valid/in_data/in_ready -> mem_we/mem_addr/
// mem_wdata, cpu_hold, done, error, last_pc. Macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [BYTE_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           last_pc
);

  localparam logic [31:0] N_MAX = 32'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [HDR_W-1:0]      n_q, n_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [HDR_W-1:0]      n_hdr;
  logic [HDR_W-1:0]      n_m1;
  logic                  rdy_st;
  logic                  accept;
  logic                  push;
  logic                  clr;
  logic                  word_full;
  logic                  is_last;
  logic [WORD_W-1:0]     word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d;
`endif

  imem_word_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push),
    .byte_in   (in_data),
    .word      (word),
    .word_full (word_full)
  );

  assign in_ready = rst && rdy_st;
  assign accept   = in_valid && in_ready;
  assign n_hdr    = {in_data, n_q[BYTE_W-1:0]};
  assign n_m1     = n_q - HDR_W'(1);
  assign is_last  = 32'(wcnt_q) == 32'(n_m1);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    rdy_st  = 1'b0;
    push    = 1'b0;
    clr     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_HDR_LO: begin
        rdy_st = 1'b1;
        if (accept) begin
          n_d[BYTE_W-1:0] = in_data;
          state_d = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        rdy_st = 1'b1;
        if (accept) begin
          n_d = n_hdr;
          if (n_hdr == '0 || 32'(n_hdr) > N_MAX)
            state_d = S_ERR;
          else
            state_d = S_BYTE;
        end
      end
      S_BYTE: begin
        rdy_st = 1'b1;
        push   = accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) csum_d = csum_q ^ in_data;
`endif
        if (word_full) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (is_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          wcnt_d  = wcnt_q + ADDR_WIDTH'(1);
          state_d = S_BYTE;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        rdy_st = 1'b1;
        if (accept)
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR_LO;
          n_d     = '0;
          wcnt_d  = '0;
          clr     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      default: state_d = S_HDR_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_HDR_LO;
      n_q     <= '0;
      wcnt_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    mem_we    = state_q == S_WRITE;
    mem_addr  = mem_we ? wcnt_q : '0;
    mem_wdata = mem_we ? DATA_WIDTH'(word) : '0;
    done      = state_q == S_DONE;
    error     = state_q == S_ERR;
    cpu_hold  = !done;
    last_pc   = done ? 32'({n_m1, 2'b00}) : '0;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader.
// Streams images and checks writes and status against a reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [31:0] last_pc;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] img [1024];
  logic [9:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int          we_ready_viol = 0;
  int          hold_viol = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .last_pc   (last_pc)
  );

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end
      if (mem_we && in_ready) we_ready_viol++;
      if (rst && (cpu_hold !== !done)) hold_viol++;
    end
  end

  function automatic int pick_gap(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(done || error) && k < 50) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: we=%b addr=%h data=%h required 0/0/0",
               mem_we, mem_addr, mem_wdata);
    end
    n_chk++;
    if (done !== 1'b0 || error !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_status: done=%b error=%b hold=%b required 0/0/1",
               done, error, cpu_hold);
    end
    n_chk++;
    if (last_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_last_pc: got %h required 0", last_pc);
    end
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 0", in_ready);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_load_image(input string name, input int n,
                                 input int mode, input bit start_mid);
    logic [7:0]  b;
    logic [7:0]  cs;
    logic [31:0] exp_pc;
    int          nw;
    if (done || error) pulse_start();
    wr_addr.delete();
    wr_data.delete();
    we_ready_viol = 0;
    hold_viol = 0;
    cs = '0;
    send_byte(8'(n), pick_gap(mode));
    send_byte(8'(n >> 8), pick_gap(mode));
    if (start_mid) pulse_start();
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'(img[i] >> (8 * j));
        cs ^= b;
        send_byte(b, pick_gap(mode));
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs, pick_gap(mode));
`endif
    idle();
    wait_end();
    exp_pc = 32'((n - 1) * 4);
    n_chk++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_status: done=%b error=%b hold=%b required 1/0/0",
               name, done, error, cpu_hold);
    end
    n_chk++;
    if (last_pc !== exp_pc) begin
      n_fail++;
      $display("FAIL %s_last_pc: got %h required %h", name, last_pc, exp_pc);
    end
    n_chk++;
    if (wr_addr.size() != n) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d required %0d",
               name, wr_addr.size(), n);
    end
    nw = (wr_addr.size() < n) ? wr_addr.size() : n;
    for (int i = 0; i < nw; i++) begin
      n_chk++;
      if (wr_addr[i] !== 10'(i) || wr_data[i] !== img[i]) begin
        n_fail++;
        $display("FAIL %s_write%0d: addr=%h data=%h required %h/%h",
                 name, i, wr_addr[i], wr_data[i], 10'(i), img[i]);
      end
    end
    n_chk++;
    if (we_ready_viol != 0) begin
      n_fail++;
      $display("FAIL %s_we_with_ready: got %0d cycles required 0",
               name, we_ready_viol);
    end
    n_chk++;
    if (hold_viol != 0) begin
      n_fail++;
      $display("FAIL %s_hold_vs_done: got %0d cycles required 0",
               name, hold_viol);
    end
  endtask

  task automatic test_back_to_back();
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    img[2] = 32'hFFF0_0113;
    test_load_image("b2b", 3, 0, 1'b0);
  endtask

  task automatic test_toggle();
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    img[2] = 32'hFFF0_0113;
    test_load_image("toggle", 3, 1, 1'b1);
  endtask

  task automatic test_header_err();
    int rdy_cnt;
    if (done || error) pulse_start();
    wr_addr.delete();
    wr_data.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    idle();
    wait_end();
    n_chk++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hdr0_status: error=%b hold=%b done=%b required 1/1/0",
               error, cpu_hold, done);
    end
    n_chk++;
    if (last_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL hdr0_last_pc: got %h required 0", last_pc);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    rdy_cnt  = 0;
    repeat (6) begin
      @(negedge clk);
      if (in_ready) rdy_cnt++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (rdy_cnt != 0 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL err_no_accept: ready_cycles=%0d error=%b required 0/1",
               rdy_cnt, error);
    end
    pulse_start();
    n_chk++;
    if (error !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL err_restart: error=%b hold=%b ready=%b required 0/1/1",
               error, cpu_hold, in_ready);
    end
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    idle();
    wait_end();
    n_chk++;
    if (error !== 1'b1 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL hdr1025_status: error=%b hold=%b required 1/1",
               error, cpu_hold);
    end
    n_chk++;
    if (wr_addr.size() != 0) begin
      n_fail++;
      $display("FAIL hdr_err_writes: got %0d required 0", wr_addr.size());
    end
  endtask

  task automatic test_reset_mid_load();
    if (done || error) pulse_start();
    wr_addr.delete();
    wr_data.delete();
    img[0] = $urandom;
    img[1] = $urandom;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int j = 0; j < 4; j++) send_byte(8'(img[0] >> (8 * j)), 0);
    send_byte(img[1][7:0], 0);
    send_byte(img[1][15:8], 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        done !== 1'b0 || error !== 1'b0 || cpu_hold !== 1'b1 ||
        last_pc !== '0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: we=%b a=%h d=%h dn=%b er=%b h=%b pc=%h r=%b required reset values",
               mem_we, mem_addr, mem_wdata, done, error, cpu_hold,
               last_pc, in_ready);
    end
    n_chk++;
    if (wr_addr.size() != 1 || wr_data[0] !== img[0]) begin
      n_fail++;
      $display("FAIL midrst_writes: count=%0d required 1 with data %h",
               wr_addr.size(), img[0]);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b required 1", in_ready);
    end
    for (int i = 0; i < 18; i++) img[i] = $urandom;
    test_load_image("reload18", 18, 2, 1'b0);
  endtask

  task automatic test_restart();
    pulse_start();
    n_chk++;
    if (done !== 1'b0 || cpu_hold !== 1'b1 || last_pc !== '0) begin
      n_fail++;
      $display("FAIL restart_clear: done=%b hold=%b pc=%h required 0/1/0",
               done, cpu_hold, last_pc);
    end
    img[0] = 32'hDEAD_BEEF;
    test_load_image("restart", 1, 0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 4; t++) begin
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) img[i] = $urandom;
      test_load_image("random", n, 2, t[0]);
    end
  endtask

  task automatic test_max();
    for (int i = 0; i < 1024; i++) img[i] = $urandom;
    test_load_image("max1024", 1024, 0, 1'b0);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] bytes [7];
    bytes[0] = 8'h01; bytes[1] = 8'h00;
    bytes[2] = 8'hEF; bytes[3] = 8'hBE;
    bytes[4] = 8'hAD; bytes[5] = 8'hDE;
    bytes[6] = 8'h22;
    for (int r = 0; r < 2; r++) begin
      if (done || error) pulse_start();
      if (r == 1) bytes[6] = 8'h23;
      for (int i = 0; i < 7; i++) send_byte(bytes[i], 0);
      idle();
      wait_end();
      n_chk++;
      if (r == 0 && (done !== 1'b1 || error !== 1'b0)) begin
        n_fail++;
        $display("FAIL csum_good: done=%b error=%b required 1/0", done, error);
      end else if (r == 1 && (error !== 1'b1 || cpu_hold !== 1'b1)) begin
        n_fail++;
        $display("FAIL csum_bad: error=%b hold=%b required 1/1",
                 error, cpu_hold);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_toggle();
    test_header_err();
    test_reset_mid_load();
    test_restart();
    test_random();
    test_max();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
